// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types, block geometry and address helper for mem_arbiter
// Purpose: arbiter state encoding, block/word geometry constants and the
// word-address helper used by the fill issue logic.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, WRITE, IFILL, DFILL} arb_state_t;

  localparam int BLOCK_WORDS = 8;   // words per cache block
  localparam int WORD_IDX_W  = 3;   // bits to index a word within a block
  localparam int BLOCK_OFS_W = 4;   // byte-offset bits within a 16-byte block
  localparam int ADDR_MAX_W  = 32;  // widest address the helper supports

  // Byte address of word idx inside the block starting at base (16-bit words).
  function automatic logic [ADDR_MAX_W-1:0] word_addr(input logic [ADDR_MAX_W-1:0] base,
                                                      input logic [WORD_IDX_W-1:0] idx);
    return base + ADDR_MAX_W'({idx, 1'b0});
  endfunction

endpackage

// File: rtl/mem_fill_seq.sv
// rtl/mem_fill_seq.sv - issue/return bookkeeping for one block fill
// Purpose: counts read issues and returns, tracks reads in flight and yields
// the word index for the next issue and for the current return.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           fill begins; word 0 of the order is issued on this edge
//   startWord       first word of the issue order
//   issue           another read is scheduled for the next cycle
//   rdOnBus         a read is on the memory bus this cycle
//   memValid        memory return, already qualified by a fill state
//   issueIdx        word index of the next read to schedule
//   issueDone       all words have been scheduled
//   retAccept       this cycle's return belongs to the fill
//   retLast         this return completes the block
//   retIdx          word index of this cycle's return
module mem_fill_seq
  import mem_arb_pkg::*;
#(
  parameter int NWORDS  = 8,
  parameter int OUTST_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WORD_IDX_W-1:0] startWord,
  input  logic                  issue,
  input  logic                  rdOnBus,
  input  logic                  memValid,
  output logic [WORD_IDX_W-1:0] issueIdx,
  output logic                  issueDone,
  output logic                  retAccept,
  output logic                  retLast,
  output logic [WORD_IDX_W-1:0] retIdx
);

  localparam int CNT_W = $clog2(NWORDS) + 1;

  logic [CNT_W-1:0]      issueCnt;
  logic [CNT_W-1:0]      retCnt;
  logic [OUTST_W-1:0]    outst;
  logic [WORD_IDX_W-1:0] firstWord;

  // Returns with nothing in flight are stray and must not be steered anywhere.
  assign retAccept = memValid && (outst != '0);
  assign retLast   = retAccept && (retCnt == CNT_W'(NWORDS - 1));
  assign issueDone = (issueCnt == CNT_W'(NWORDS));
  // Index arithmetic wraps modulo the block size for critical-word-first order.
  assign issueIdx  = firstWord + issueCnt[WORD_IDX_W-1:0];
  assign retIdx    = firstWord + retCnt[WORD_IDX_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issueCnt  <= '0;
      retCnt    <= '0;
      outst     <= '0;
      firstWord <= '0;
    end else if (start) begin
      // The first read is scheduled together with start, so count it now.
      issueCnt  <= CNT_W'(1);
      retCnt    <= '0;
      outst     <= '0;
      firstWord <= startWord;
    end else begin
      if (issue)     issueCnt <= issueCnt + CNT_W'(1);
      if (retAccept) retCnt   <= retCnt + CNT_W'(1);
      if (rdOnBus && !retAccept)      outst <= outst + OUTST_W'(1);
      else if (!rdOnBus && retAccept) outst <= outst - OUTST_W'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shared-memory arbiter for D-cache writes and I/D block fills
// Purpose: arbitrates D-cache write-through, D-cache fills and I-cache fills
// onto one pipelined memory; steers returning words and pulses completion.
// Optional build macro: MEM_ARB_CWF_EN (critical word first issue order).
// Ports:
//   clk, rst                           clock, asynchronous active-high reset
//   i_miss, i_miss_addr                I-cache fill request / byte address
//   d_miss, d_miss_addr                D-cache fill request / byte address
//   d_wr_req, d_wr_addr, d_wr_data     D-cache write-through request
//   fill_data, fill_word               returned word and its block index
//   i_fill_we, d_fill_we               write strobe into the owning cache
//   i_fill_done, d_fill_done           block-complete pulses
//   d_wr_ack                           write issued pulse
//   mem_enable, mem_wr, mem_addr,
//   mem_data_in                        registered memory request
//   mem_data_out, mem_data_valid       memory read return
module mem_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int BLOCK_WORDS = mem_arb_pkg::BLOCK_WORDS,
  parameter int MEM_LATENCY = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_miss,
  input  logic [ADDR_W-1:0]                 i_miss_addr,
  input  logic                              d_miss,
  input  logic [ADDR_W-1:0]                 d_miss_addr,
  input  logic                              d_wr_req,
  input  logic [ADDR_W-1:0]                 d_wr_addr,
  input  logic [DATA_W-1:0]                 d_wr_data,
  output logic [DATA_W-1:0]                 fill_data,
  output logic [mem_arb_pkg::WORD_IDX_W-1:0] fill_word,
  output logic                              i_fill_we,
  output logic                              d_fill_we,
  output logic                              i_fill_done,
  output logic                              d_fill_done,
  output logic                              d_wr_ack,
  output logic                              mem_enable,
  output logic                              mem_wr,
  output logic [ADDR_W-1:0]                 mem_addr,
  output logic [DATA_W-1:0]                 mem_data_in,
  input  logic [DATA_W-1:0]                 mem_data_out,
  input  logic                              mem_data_valid
);

  import mem_arb_pkg::*;

  // Reads in flight never exceed the latency (or the block size).
  localparam int OUTST_MAX = (MEM_LATENCY < BLOCK_WORDS) ? MEM_LATENCY : BLOCK_WORDS;
  localparam int OUTST_W   = $clog2(OUTST_MAX + 1);

  arb_state_t            state, stateNxt;
  logic [ADDR_W-1:0]     fillBase, fillBaseNxt;
  logic                  memEnableNxt, memWrNxt, dWrAckNxt;
  logic [ADDR_W-1:0]     memAddrNxt;
  logic [DATA_W-1:0]     memDataInNxt;

  logic [ADDR_W-1:0]     missAddr, missBase;
  logic [WORD_IDX_W-1:0] startWord;
  logic                  seqStart, seqIssue, inFill;
  logic [WORD_IDX_W-1:0] issueIdx, retIdx;
  logic                  issueDone, retAccept, retLast;

  assign missAddr = d_miss ? d_miss_addr : i_miss_addr;
  assign missBase = missAddr & ~ADDR_W'((2 ** BLOCK_OFS_W) - 1);
`ifdef MEM_ARB_CWF_EN
  assign startWord = missAddr[BLOCK_OFS_W-1:1];
`else
  assign startWord = '0;
`endif

  assign inFill = (state == IFILL) || (state == DFILL);

  mem_fill_seq #(
    .NWORDS (BLOCK_WORDS),
    .OUTST_W(OUTST_W)
  ) uFillSeq (
    .clk      (clk),
    .rst      (rst),
    .start    (seqStart),
    .startWord(startWord),
    .issue    (seqIssue),
    .rdOnBus  (mem_enable && !mem_wr),
    .memValid (mem_data_valid && inFill),
    .issueIdx (issueIdx),
    .issueDone(issueDone),
    .retAccept(retAccept),
    .retLast  (retLast),
    .retIdx   (retIdx)
  );

  // Memory-side outputs are computed one cycle ahead and registered below.
  always_comb begin
    stateNxt     = state;
    fillBaseNxt  = fillBase;
    memEnableNxt = 1'b0;
    memWrNxt     = 1'b0;
    memAddrNxt   = '0;
    memDataInNxt = '0;
    dWrAckNxt    = 1'b0;
    seqStart     = 1'b0;
    seqIssue     = 1'b0;
    case (state)
      IDLE: begin
        if (d_wr_req) begin
          stateNxt     = WRITE;
          memEnableNxt = 1'b1;
          memWrNxt     = 1'b1;
          memAddrNxt   = d_wr_addr;
          memDataInNxt = d_wr_data;
          dWrAckNxt    = 1'b1;
        end else if (d_miss || i_miss) begin
          stateNxt     = d_miss ? DFILL : IFILL;
          fillBaseNxt  = missBase;
          seqStart     = 1'b1;
          memEnableNxt = 1'b1;
          memAddrNxt   = ADDR_W'(word_addr(ADDR_MAX_W'(missBase), startWord));
        end
      end
      WRITE: stateNxt = IDLE;
      IFILL, DFILL: begin
        if (!issueDone) begin
          seqIssue     = 1'b1;
          memEnableNxt = 1'b1;
          memAddrNxt   = ADDR_W'(word_addr(ADDR_MAX_W'(fillBase), issueIdx));
        end
        if (retLast) stateNxt = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      fillBase    <= '0;
      mem_enable  <= 1'b0;
      mem_wr      <= 1'b0;
      mem_addr    <= '0;
      mem_data_in <= '0;
      d_wr_ack    <= 1'b0;
    end else begin
      state       <= stateNxt;
      fillBase    <= fillBaseNxt;
      mem_enable  <= memEnableNxt;
      mem_wr      <= memWrNxt;
      mem_addr    <= memAddrNxt;
      mem_data_in <= memDataInNxt;
      d_wr_ack    <= dWrAckNxt;
    end
  end

  // Return steering is combinational so the cache can write in the return cycle.
  assign fill_data   = retAccept ? mem_data_out : '0;
  assign fill_word   = retAccept ? retIdx : '0;
  assign i_fill_we   = retAccept && (state == IFILL);
  assign d_fill_we   = retAccept && (state == DFILL);
  assign i_fill_done = retLast && (state == IFILL);
  assign d_fill_done = retLast && (state == DFILL);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

`ifdef MEM_ARB_CWF_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Per-DUT signals: DUT 0 has latency 4, DUT 1 latency 1, DUT 2 latency 6.
  logic        iMiss [3], dMiss [3], dWrReq [3], inj [3];
  logic [15:0] iMissAddr [3], dMissAddr [3], dWrAddr [3], dWrData [3];
  logic [15:0] fillData [3], memAddr [3], memDin [3], memDout [3];
  logic [2:0]  fillWord [3];
  logic        iWe [3], dWe [3], iDone [3], dDone [3], wrAck [3];
  logic        memEn [3], memWr [3], memValid [3];

  for (genvar g = 0; g < 3; g++) begin : gDut
    localparam int L = (g == 0) ? 4 : (g == 1) ? 1 : 6;
    logic [L-1:0] vPipe;
    logic [15:0]  aPipe [L];

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        vPipe <= '0;
        for (int i = 0; i < L; i++) aPipe[i] <= '0;
      end else begin
        for (int i = L - 1; i > 0; i--) begin
          vPipe[i] <= vPipe[i-1];
          aPipe[i] <= aPipe[i-1];
        end
        vPipe[0] <= memEn[g] && !memWr[g];
        aPipe[0] <= memAddr[g];
      end
    end

    assign memValid[g] = vPipe[L-1] | inj[g];
    assign memDout[g]  = inj[g] ? 16'hDEAD : (aPipe[L-1] ^ 16'hA5A5);

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .BLOCK_WORDS(8), .MEM_LATENCY(L)) uDut (
      .clk(clk), .rst(rst),
      .i_miss(iMiss[g]), .i_miss_addr(iMissAddr[g]),
      .d_miss(dMiss[g]), .d_miss_addr(dMissAddr[g]),
      .d_wr_req(dWrReq[g]), .d_wr_addr(dWrAddr[g]), .d_wr_data(dWrData[g]),
      .fill_data(fillData[g]), .fill_word(fillWord[g]),
      .i_fill_we(iWe[g]), .d_fill_we(dWe[g]),
      .i_fill_done(iDone[g]), .d_fill_done(dDone[g]), .d_wr_ack(wrAck[g]),
      .mem_enable(memEn[g]), .mem_wr(memWr[g]), .mem_addr(memAddr[g]),
      .mem_data_in(memDin[g]), .mem_data_out(memDout[g]), .mem_data_valid(memValid[g])
    );
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Event log of the DUT selected by monDut, sampled on the falling edge.
  int          monDut = 0;
  logic [15:0] rdAddr [$], wrAddr [$], wrData [$], weData [$];
  int          rdCyc [$], wrCyc [$], ackCyc [$], weCyc [$], doneCyc [$];
  logic [2:0]  weWord [$];
  bit          weSide [$], doneSide [$];

  always @(negedge clk) begin
    if (!rst) begin
      if (memEn[monDut] && !memWr[monDut]) begin
        rdAddr.push_back(memAddr[monDut]); rdCyc.push_back(cyc);
      end
      if (memEn[monDut] && memWr[monDut]) begin
        wrAddr.push_back(memAddr[monDut]); wrData.push_back(memDin[monDut]); wrCyc.push_back(cyc);
      end
      if (wrAck[monDut]) ackCyc.push_back(cyc);
      if (iWe[monDut]) begin
        weSide.push_back(1'b0); weWord.push_back(fillWord[monDut]);
        weData.push_back(fillData[monDut]); weCyc.push_back(cyc);
      end
      if (dWe[monDut]) begin
        weSide.push_back(1'b1); weWord.push_back(fillWord[monDut]);
        weData.push_back(fillData[monDut]); weCyc.push_back(cyc);
      end
      if (iDone[monDut]) begin doneSide.push_back(1'b0); doneCyc.push_back(cyc); end
      if (dDone[monDut]) begin doneSide.push_back(1'b1); doneCyc.push_back(cyc); end
    end
  end

  task automatic clearLogs();
    rdAddr.delete(); rdCyc.delete(); wrAddr.delete(); wrData.delete(); wrCyc.delete();
    ackCyc.delete(); weSide.delete(); weWord.delete(); weData.delete(); weCyc.delete();
    doneSide.delete(); doneCyc.delete();
  endtask

  function automatic logic [38:0] outsOf(input int d);
    return {memEn[d], memWr[d], memAddr[d], fillData[d], iWe[d], dWe[d], iDone[d], dDone[d], wrAck[d]};
  endfunction

  // Requester behaviour: drop each request in the cycle after its done/ack.
  task automatic service(input int d, input int budget);
    int n = 0;
    bit idle = 1'b0;
    while (!idle && n < budget) begin
      bit dropI, dropD, dropW;
      @(negedge clk);
      dropI = iDone[d]; dropD = dDone[d]; dropW = wrAck[d];
      @(posedge clk); #1;
      if (dropI) iMiss[d] = 1'b0;
      if (dropD) dMiss[d] = 1'b0;
      if (dropW) dWrReq[d] = 1'b0;
      n++;
      idle = !iMiss[d] && !dMiss[d] && !dWrReq[d];
    end
    chk("service_complete", {31'd0, idle}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  typedef struct {
    int          dut;
    bit          isD;
    logic [15:0] addr;
    logic [15:0] base;
    logic [2:0]  w0;
    int          doneOfs;
  } fillVec_t;

  // Checks reads/returns of the fill logged starting at index off.
  task automatic checkFill(input string tag, input fillVec_t v, input int off, input int t0);
    for (int k = 0; k < 8; k++) begin
      logic [2:0]  w;
      logic [15:0] a;
      w = v.w0 + 3'(k);
      a = v.base + {12'd0, w, 1'b0};
      if (rdAddr.size() > off + k) begin
        chk({tag, "_rd_addr"}, rdAddr[off+k], a);
        chk({tag, "_rd_cyc"}, rdCyc[off+k], t0 + k);
      end
      if (weWord.size() > off + k) begin
        chk({tag, "_we_side"}, {31'd0, weSide[off+k]}, {31'd0, v.isD});
        chk({tag, "_fill_word"}, weWord[off+k], w);
        chk({tag, "_fill_data"}, weData[off+k], a ^ 16'hA5A5);
        chk({tag, "_we_cyc"}, weCyc[off+k], t0 + k + v.doneOfs - 7);
      end
    end
  endtask

  task automatic runFill(input string tag, input fillVec_t v);
    int c0;
    clearLogs();
    monDut = v.dut;
    @(posedge clk); #1;
    c0 = cyc;
    if (v.isD) begin dMiss[v.dut] = 1'b1; dMissAddr[v.dut] = v.addr; end
    else begin iMiss[v.dut] = 1'b1; iMissAddr[v.dut] = v.addr; end
    service(v.dut, 60);
    chk({tag, "_rd_count"}, rdAddr.size(), 8);
    chk({tag, "_we_count"}, weWord.size(), 8);
    chk({tag, "_wr_count"}, wrAddr.size() + ackCyc.size(), 0);
    checkFill(tag, v, 0, c0 + 1);
    chk({tag, "_done_count"}, doneSide.size(), 1);
    if (doneSide.size() == 1) begin
      chk({tag, "_done_side"}, {31'd0, doneSide[0]}, {31'd0, v.isD});
      chk({tag, "_done_cyc"}, doneCyc[0], c0 + 1 + v.doneOfs);
    end
  endtask

  fillVec_t vecs [5];

  initial begin
    int c0, cnt;
    fillVec_t pv;
    vecs[0] = '{0, 1'b0, 16'h0126, 16'h0120, CWF ? 3'd3 : 3'd0, 11};
    vecs[1] = '{0, 1'b1, 16'h004A, 16'h0040, CWF ? 3'd5 : 3'd0, 11};
    vecs[2] = '{1, 1'b0, 16'h3F10, 16'h3F10, 3'd0, 8};
    vecs[3] = '{2, 1'b1, 16'hFFFE, 16'hFFF0, CWF ? 3'd7 : 3'd0, 13};
    vecs[4] = '{0, 1'b1, 16'h8001, 16'h8000, 3'd0, 11};

    for (int d = 0; d < 3; d++) begin
      iMiss[d] = 0; dMiss[d] = 0; dWrReq[d] = 0; inj[d] = 0;
      iMissAddr[d] = 0; dMissAddr[d] = 0; dWrAddr[d] = 0; dWrData[d] = 0;
    end

    // Reset state.
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) chk($sformatf("reset_outs_%0d", d), 32'(outsOf(d)), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Table-driven single fills, including latency 1 and 6 instances.
    for (int i = 0; i < 5; i++) runFill($sformatf("vec%0d", i), vecs[i]);

    // Simultaneous requests: write, then D fill, then I fill.
    clearLogs(); monDut = 0;
    @(posedge clk); #1;
    c0 = cyc;
    dWrReq[0] = 1; dWrAddr[0] = 16'h0ABC; dWrData[0] = 16'h5A5A;
    dMiss[0] = 1; dMissAddr[0] = 16'h0456;
    iMiss[0] = 1; iMissAddr[0] = 16'h0789;
    service(0, 80);
    chk("prio_ack_cyc", ackCyc.size() == 1 ? ackCyc[0] : -1, c0 + 1);
    chk("prio_wr_count", wrAddr.size(), 1);
    if (wrAddr.size() == 1) begin
      chk("prio_wr_cyc", wrCyc[0], c0 + 1);
      chk("prio_wr_addr", wrAddr[0], 16'h0ABC);
      chk("prio_wr_data", wrData[0], 16'h5A5A);
    end
    chk("prio_rd_count", rdAddr.size(), 16);
    chk("prio_we_count", weWord.size(), 16);
    pv = '{0, 1'b1, 16'h0456, 16'h0450, CWF ? 3'd3 : 3'd0, 11};
    checkFill("prio_d", pv, 0, c0 + 3);
    pv = '{0, 1'b0, 16'h0789, 16'h0780, CWF ? 3'd4 : 3'd0, 11};
    checkFill("prio_i", pv, 8, c0 + 16);
    chk("prio_done_count", doneSide.size(), 2);
    if (doneSide.size() == 2) begin
      chk("prio_d_done", {doneSide[0], 31'(doneCyc[0])}, {1'b1, 31'(c0 + 14)});
      chk("prio_i_done", {doneSide[1], 31'(doneCyc[1])}, {1'b0, 31'(c0 + 27)});
    end

    // Write raised during an I fill waits for completion.
    clearLogs(); monDut = 0;
    @(posedge clk); #1;
    c0 = cyc;
    iMiss[0] = 1; iMissAddr[0] = 16'h0200;
    repeat (3) @(posedge clk); #1;
    dWrReq[0] = 1; dWrAddr[0] = 16'h1234; dWrData[0] = 16'hBEEF;
    service(0, 60);
    chk("wdf_i_done", doneCyc.size() == 1 ? doneCyc[0] : -1, c0 + 12);
    chk("wdf_wr_count", wrAddr.size(), 1);
    if (wrAddr.size() == 1) begin
      chk("wdf_wr_cyc", wrCyc[0], c0 + 14);
      chk("wdf_wr_addr", wrAddr[0], 16'h1234);
      chk("wdf_wr_data", wrData[0], 16'hBEEF);
    end
    chk("wdf_ack_cyc", ackCyc.size() == 1 ? ackCyc[0] : -1, c0 + 14);
    chk("wdf_rd_count", rdAddr.size(), 8);

    // Asynchronous reset at the 5th return of a D fill.
    clearLogs(); monDut = 0;
    @(posedge clk); #1;
    dMiss[0] = 1; dMissAddr[0] = 16'h0300;
    cnt = 0;
    for (int n = 0; n < 40 && cnt < 5; n++) begin
      @(negedge clk);
      if (dWe[0]) cnt++;
    end
    chk("rst_fifth_return_seen", cnt, 5);
    rst = 1'b1;
    #1;
    chk("rst_outs_zero", 32'(outsOf(0)), 32'd0);
    dMiss[0] = 0;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("rst_no_done", doneSide.size(), 0);
    pv = '{0, 1'b1, 16'h0300, 16'h0300, 3'd0, 11};
    runFill("rst_refill", pv);

    // Stray mem_data_valid in IDLE must be ignored.
    for (int d = 1; d < 3; d++) begin
      clearLogs(); monDut = d;
      @(posedge clk); #1;
      inj[d] = 1;
      repeat (2) @(posedge clk); #1;
      inj[d] = 0;
      repeat (2) @(posedge clk); #1;
      chk($sformatf("idle_valid_we_%0d", d), weWord.size() + doneSide.size(), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits between the I-cache, the D-cache and the single shared multi-cycle pipelined main memory.
- Arbitrates D-cache word writes (write-through), D-cache block fills and I-cache block fills.
- For a fill, issues the block's word reads back-to-back, then steers the returning data to the requesting cache.
- Signals completion, so the pipeline stall on a cache miss is released by this block.

Parameters:
- ADDR_W, 16: byte address width.
- DATA_W, 16: memory word width.
- BLOCK_WORDS, 8: words per cache block (16-byte blocks).
- MEM_LATENCY, 4: cycles from a read issue to its mem_data_valid.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_miss  in  1  I-cache fill request; held until i_fill_done.
- i_miss_addr  in  ADDR_W  I-cache miss byte address.
- d_miss  in  1  D-cache fill request; held until d_fill_done.
- d_miss_addr  in  ADDR_W  D-cache miss byte address.
- d_wr_req  in  1  D-cache write-through request; held until d_wr_ack.
- d_wr_addr  in  ADDR_W  write byte address.
- d_wr_data  in  DATA_W  write data.
- fill_data  out  DATA_W  returned word; shared by both caches.
- fill_word  out  3  word index of fill_data within the block.
- i_fill_we  out  1  write fill_data into the I-cache data array.
- d_fill_we  out  1  write fill_data into the D-cache data array.
- i_fill_done  out  1  one-cycle pulse: I-cache block complete.
- d_fill_done  out  1  one-cycle pulse: D-cache block complete.
- d_wr_ack  out  1  one-cycle pulse: write issued.
- mem_enable  out  1  memory access this cycle.
- mem_wr  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  memory byte address.
- mem_data_in  out  DATA_W  memory write data.
- mem_data_out  in  DATA_W  memory read data.
- mem_data_valid  in  1  mem_data_out valid.

Behaviour:
- Clock and reset: one clock (clk). Reset rst is asynchronous and active-high.
- Reset:
  - state = IDLE.
  - Issue, return and outstanding counters = 0.
  - Every output = 0.
  - Memory shares rst, so no stale returns exist after reset.
- States: IDLE, WRITE, IFILL, DFILL.
- IDLE priority: d_wr_req > d_miss > i_miss. The request is latched in IDLE; the next state is entered on the following edge.
- WRITE (exactly 1 cycle):
  - mem_enable = 1, mem_wr = 1, mem_addr = d_wr_addr, mem_data_in = d_wr_data, d_wr_ack = 1.
  - Then IDLE.
- IFILL / DFILL:
  - base = latched addr with low 4 bits cleared.
  - Issue phase: for issue count k = 0..7 on consecutive cycles, mem_enable = 1, mem_wr = 0, mem_addr = base + 2*k.
  - mem_enable = 0 once 8 reads have been issued.
  - Each mem_data_valid while outstanding > 0 increments the return count r. The same cycle (combinational), fill_data = mem_data_out, fill_word = word of the r-th issue, and the owning *_fill_we = 1.
  - The 8th return asserts *_fill_done in the same cycle as its *_fill_we. Next state is IDLE.
- Timing: first issue at cycle T, last issue at T+7, returns at T+MEM_LATENCY .. T+7+MEM_LATENCY. Done at T+7+MEM_LATENCY.
- Ignored inputs:
  - mem_data_valid is ignored in IDLE, in WRITE, and when outstanding = 0.
  - Requests arriving mid-operation wait; no preemption.
  - Requesters deassert in the cycle after done/ack. IDLE always lasts at least 1 cycle between operations.
- Starvation: i_miss may starve under continuous D traffic. This is accepted because D requests stall the pipeline.
- Outputs: mem_* are registered (Moore). fill_* and *_we / done follow mem_data_valid combinationally.
- Reset mid-fill: abort immediately; no done pulse; the requester re-requests after reset.

Optional Feature:
- Macro MEM_ARB_CWF_EN (critical word first).
- Defined: the issue order starts at word w0 = addr[3:1] and wraps modulo 8 (word index (w0+k) mod 8). fill_word follows that order, so the first return is the missed word.
- Undefined: the order is always word 0..7.

Decomposition:
- Package mem_arb_pkg holds:
  - the arb_state_t enum (IDLE, WRITE, IFILL, DFILL);
  - BLOCK_WORDS, WORD_IDX_W = 3, BLOCK_OFS_W = 4;
  - the function word_addr(base, idx).
- One sub-module, mem_fill_seq, holds the issue counter, return counter, outstanding count and fill_word generation. It is instantiated once and reset when a fill starts.

Test Plan:
- I-fill: i_miss = 1, i_miss_addr = 0x0126, memory returns (addr ^ 0xA5A5).
  - Reads issued at 0x0120..0x012E.
  - i_fill_we 8×, fill_word 0..7.
  - i_fill_done at T+11.
  - d_* outputs all quiet.
- Priority: d_miss, i_miss and d_wr_req asserted in the same cycle.
  - Order: WRITE (d_wr_ack, mem_wr = 1, addr/data correct), then the D fill, then the I fill.
  - IDLE ≥ 1 cycle between each.
- Write during fill: d_wr_req raised mid-IFILL.
  - No mem_wr until after i_fill_done.
  - d_wr_ack arrives within 2 cycles after IDLE.
- Async reset: rst asserted at the 5th return of a D-fill.
  - All outputs 0 immediately, no d_fill_done.
  - A new d_miss after release completes normally with 8 returns.
- Latency: MEM_LATENCY = 1 and 6.
  - done at T+8 and T+13 respectively.
  - mem_data_valid injected in IDLE is ignored (no *_we).
- CWF (MEM_ARB_CWF_EN defined), d_miss_addr = 0x004A:
  - Issue order 0x004A, 0x004C, 0x004E, 0x0040 … 0x0048.
  - fill_word 5, 6, 7, 0, …, 4.
